// File: rtl/multiword_sub_ctrl_pkg.sv
// multiword_sub_ctrl_pkg
//   Shared definitions for the multi-word subtract sequencer.
//   - state_t     : controller state encoding (IDLE, RUN, DONE)
//   - NIBBLE_W    : width of one subtractor slice
//   - clog2_int() : ceiling log2, used to size the nibble index
package multiword_sub_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1 bit so a counter always has a width.
  function automatic int clog2_int(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/multiword_sub_ctrl_if.sv
// multiword_sub_ctrl_if
//   Host-side handshake and operand/result bus of the sequencer.
//   Signals:
//     start     : request pulse from host
//     a, b      : minuend / subtrahend, WORDS nibbles wide
//     borrowIn  : initial borrow into nibble 0
//     busy      : operation in progress
//     done      : one-cycle result-valid pulse
//     diff      : a - b - borrowIn modulo 2^WIDTH
//     borrowOut : borrow out of the top nibble
//     zero      : diff == 0
//   Modports: master (host side), slave (sequencer side).
interface multiword_sub_ctrl_if
  import multiword_sub_ctrl_pkg::*;
#(
  parameter int WORDS = 4
);

  localparam int WIDTH = NIBBLE_W * WORDS;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrowIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrowOut;
  logic             zero;

  modport master (
    output start, a, b, borrowIn,
    input  busy, done, diff, borrowOut, zero
  );

  modport slave (
    input  start, a, b, borrowIn,
    output busy, done, diff, borrowOut, zero
  );

endinterface

// File: rtl/multiword_sub_ctrl_parallel_sub.sv
// parallel_sub
//   The existing 4-bit ripple-borrow subtractor slice (purely combinational).
//   Ports:
//     a, b      : 4-bit operands
//     borrowIn  : borrow from the previous, less significant slice
//     diff      : a - b - borrowIn, modulo 16
//     borrowOut : 1 when the subtraction needed to borrow
module parallel_sub
  import multiword_sub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                borrowIn,
  output logic [NIBBLE_W-1:0] diff,
  output logic                borrowOut
);

  logic [NIBBLE_W:0] full_diff;

  // Subtracting in one extra bit makes the MSB the borrow: it goes to 1
  // exactly when the true result is negative.
  always_comb begin
    full_diff = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, borrowIn};
    diff      = full_diff[NIBBLE_W-1:0];
    borrowOut = full_diff[NIBBLE_W];
  end

endmodule

// File: rtl/multiword_sub_ctrl.sv
// multiword_sub_ctrl
//   Computes a WORDS*4-bit subtraction by running one 4-bit parallel_sub
//   slice for WORDS cycles, least significant nibble first, with the borrow
//   kept in a register between cycles.
//   Ports:
//     clk  : rising-edge clock
//     rstN : asynchronous active-low reset
//     bus  : slave side of multiword_sub_ctrl_if (start/busy/done handshake,
//            operands, result, borrowOut, zero)
module multiword_sub_ctrl
  import multiword_sub_ctrl_pkg::*;
#(
  parameter int WORDS = 4
)(
  input  logic                 clk,
  input  logic                 rstN,
  multiword_sub_ctrl_if.slave  bus
);

  localparam int                WIDTH    = NIBBLE_W * WORDS;
  localparam int                IDX_W    = clog2_int(WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [WIDTH-1:0]    diff_reg;
  logic [WIDTH-1:0]    diff_next;
  logic [IDX_W-1:0]    idx;
  logic                borrow_reg;
  logic                borrow_out_reg;
  logic                zero_reg;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_diff;
  logic                slice_borrow;

  logic                accept;
  logic                last_nibble;

  // The single shared slice.
  parallel_sub u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .borrowIn  (borrow_reg),
    .diff      (slice_diff),
    .borrowOut (slice_borrow)
  );

  // Slice operand selection and the result with the current nibble merged
  // in; the merged value lets zero be judged on the complete result in the
  // same edge that writes the last nibble.
  always_comb begin
    slice_a   = a_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
    slice_b   = b_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
    diff_next = diff_reg;
    diff_next[int'(idx)*NIBBLE_W +: NIBBLE_W] = slice_diff;
  end

  // Next-state and handshake outputs. DONE accepts a start just like IDLE,
  // so back-to-back operations need no idle bubble.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    last_nibble = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          last_nibble = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand, borrow, index and result registers. Operands are captured only
  // on an accepted start, so host changes during RUN have no effect. The
  // index stops at LAST_IDX and is cleared by the next accepted start.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_reg          <= '0;
      b_reg          <= '0;
      diff_reg       <= '0;
      idx            <= '0;
      borrow_reg     <= 1'b0;
      borrow_out_reg <= 1'b0;
      zero_reg       <= 1'b0;
    end else if (accept) begin
      a_reg      <= bus.a;
      b_reg      <= bus.b;
      borrow_reg <= bus.borrowIn;
      idx        <= '0;
      diff_reg   <= '0;
    end else if (state == RUN) begin
      diff_reg   <= diff_next;
      borrow_reg <= slice_borrow;
      if (last_nibble) begin
        borrow_out_reg <= slice_borrow;
        zero_reg       <= (diff_next == '0);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.diff      = diff_reg;
  assign bus.borrowOut = borrow_out_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_multiword_sub_ctrl.sv
// tb_multiword_sub_ctrl
//   Scoreboard bench for multiword_sub_ctrl (WORDS = 4). Each accepted start
//   pushes the expected result and the cycle its done should appear; a
//   monitor pops and compares on every done pulse.
module tb_multiword_sub_ctrl;
  import multiword_sub_ctrl_pkg::*;

  localparam int WORDS = 4;
  localparam int WIDTH = NIBBLE_W * WORDS;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrowOut;
    logic             zero;
    int               doneCycle;
  } exp_t;

  logic clk;
  logic rstN;
  int   cycle;
  int   checksTotal;
  int   checksPassed;
  int   busyRun;
  exp_t expQ[$];

  multiword_sub_ctrl_if #(.WORDS(WORDS)) bus();

  multiword_sub_ctrl #(.WORDS(WORDS)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: the whole-word arithmetic, not a nibble walk.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, input int doneCycle);
    exp_t   e;
    longint full;
    full        = longint'(a) - longint'(b) - longint'(bin);
    e.diff      = WIDTH'(full);
    e.borrowOut = (longint'(a) < longint'(b) + longint'(bin));
    e.zero      = (e.diff == '0);
    e.doneCycle = doneCycle;
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checksTotal++;
    if (actual == expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Called just after a negedge. Holds start for one cycle. When the start
  // is expected to be accepted, the accept edge is the next posedge, so done
  // becomes visible WORDS cycles later.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic bin, input bit expectAccept);
    bus.a        = a;
    bus.b        = b;
    bus.borrowIn = bin;
    bus.start    = 1'b1;
    if (expectAccept) expQ.push_back(model(a, b, bin, cycle + 1 + WORDS));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("wait ready timeout busy", bus.busy, 0);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("wait done timeout done", bus.done, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !bus.busy && !bus.done) break;
    end
    checkOutput("drain pending results", expQ.size(), 0);
  endtask

  // Monitor: every done pulse must match the oldest expectation, appear on
  // the predicted cycle, follow exactly WORDS busy cycles and last one cycle.
  initial begin
    exp_t e;
    logic prevDone;
    busyRun  = 0;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (bus.busy) busyRun++;
        if (bus.done) begin
          checkOutput("done single-cycle", prevDone, 0);
          if (expQ.size() == 0) begin
            checkOutput("done with empty scoreboard", bus.done, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("diff", bus.diff, e.diff);
            checkOutput("borrowOut", bus.borrowOut, e.borrowOut);
            checkOutput("zero", bus.zero, e.zero);
            checkOutput("done cycle", cycle, e.doneCycle);
            checkOutput("busy cycles", busyRun, WORDS);
            checkOutput("busy low in done", bus.busy, 0);
          end
          busyRun = 0;
        end
        prevDone = bus.done;
      end else begin
        prevDone = 1'b0;
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    checksTotal  = 0;
    checksPassed = 0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.borrowIn = 1'b0;

    // Reset held with start high: nothing may start.
    rstN      = 1'b0;
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h0235;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset diff", bus.diff, 0);
    checkOutput("reset borrowOut", bus.borrowOut, 0);
    checkOutput("reset zero", bus.zero, 0);
    bus.start = 1'b0;
    rstN      = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle after reset busy", bus.busy, 0);

    // Directed arithmetic cases.
    applyStimulus(16'h1234, 16'h0235, 1'b0, 1'b1);
    drain();
    applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b1);
    drain();
    applyStimulus(16'hA5A5, 16'hA5A5, 1'b1, 1'b1);
    drain();
    applyStimulus(16'h0005, 16'h0004, 1'b1, 1'b1);
    drain();

    // Start mid-RUN with new operands: ignored, first result still stands.
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    applyStimulus(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    drain();

    // Start in the done cycle is accepted without a bubble.
    applyStimulus(16'hBEEF, 16'h1234, 1'b0, 1'b1);
    waitDone();
    applyStimulus(16'h0F0F, 16'hF0F0, 1'b1, 1'b1);
    drain();

    // Randomized operations, sometimes back-to-back, sometimes with an
    // ignored start during RUN.
    for (int i = 0; i < 24; i++) begin
      waitReady();
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
      end
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    drain();

    // Reset two cycles into RUN aborts without a done pulse.
    applyStimulus(16'h4321, 16'h1234, 1'b0, 1'b1);
    @(negedge clk);
    rstN = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort done", bus.done, 0);
    checkOutput("abort diff", bus.diff, 0);
    checkOutput("abort borrowOut", bus.borrowOut, 0);
    checkOutput("abort zero", bus.zero, 0);
    busyRun = 0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("no done after abort", bus.done, 0);
    applyStimulus(16'h9000, 16'h0001, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/multiword_sub_ctrl.md
Name: multiword_sub_ctrl

Overview:
- Sequencer that computes a wide subtraction (WORDS × 4 bits) by time-multiplexing one 4-bit ripple-borrow subtractor slice.
- Processes one nibble per cycle, least significant first, carrying the borrow in a register between cycles.
- Uses a start/busy/done handshake.
- Sits between a host/register block and the existing 4-bit subtractor datapath. Lets wide operands reuse a single small slice.

Parameters:
- WORDS, 4, number of 4-bit nibbles per operand (≥2). Operand width WIDTH = 4*WORDS.

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only while not busy
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- borrowIn  input  1  initial borrow into nibble 0; captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- diff  output  WIDTH  result a − b − borrowIn, modulo 2^WIDTH
- borrowOut  output  1  final borrow out of the top nibble
- zero  output  1  diff == 0, valid with diff

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstN.
- Reset values (rstN low, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrowOut=0, zero=0. Nibble index, borrow register and operand registers are all 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - Latch a, b and borrowIn.
  - Clear the nibble index and the diff register.
  - Go to RUN; busy=1 from that edge.
- RUN:
  - Slice inputs are the index-selected nibbles of the latched a and b, plus the borrow register.
  - Each edge writes the slice difference into diff nibble[index] and the slice borrow into the borrow register, then increments the index.
  - At the edge where index == WORDS−1: write the last nibble, load borrowOut from the slice borrow, compute zero from the complete result, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - A start sampled in DONE is accepted exactly as in IDLE: go to RUN, busy=1 next cycle, no idle bubble.
- Latency: start sampled at edge E0 → done high in the cycle after edge E(WORDS). The operation takes WORDS cycles of RUN; throughput is one operation per WORDS+1 cycles.
- Result stability:
  - diff, borrowOut and zero hold their values from DONE until the next accepted start.
  - After an accepted start, diff reads partial results during RUN and must not be used until done.
- start while busy (RUN) is ignored. Operand changes during RUN have no effect, since the latched copies are used.
- Arithmetic:
  - Per slice: {borrow, nibble} = A_n − B_n − borrow_prev, 4-bit modular.
  - Overall: borrowOut=1 iff a < b + borrowIn (unsigned).
- The index counter width is clog2(WORDS). The index never exceeds WORDS−1 and does not wrap during RUN.
- Reset mid-operation: abort immediately to IDLE. No done pulse is produced and outputs go to their reset values.
- Back-to-back: the start of the next operation may coincide with the done cycle. done still pulses for the first operation.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE), nibble width constant 4, clog2 helper.
- One sub-module: the existing 4-bit subtractor slice, parallel_sub (ports a, b, borrowIn, diff, borrowOut), instantiated once. Everything else is the controller FSM plus the operand, borrow and result registers in this module.

Test Plan:
- Reset: hold rstN=0 with start=1 → busy=0, done=0, diff=0x0000, borrowOut=0. After release, nothing starts until start is sampled.
- Basic, WORDS=4: a=0x1234, b=0x0235, borrowIn=0, start 1 cycle → done exactly 4 cycles after the start edge with diff=0x0FFF, borrowOut=0, zero=0. busy high for exactly 4 cycles.
- Wrap/borrow: a=0x0000, b=0x0001, borrowIn=0 → diff=0xFFFF, borrowOut=1, zero=0. Then a=0xA5A5, b=0xA5A5, borrowIn=1 → diff=0xFFFF, borrowOut=1.
- Zero flag: a=0x0005, b=0x0004, borrowIn=1 → diff=0x0000, borrowOut=0, zero=1.
- Handshake:
  - Pulse start again mid-RUN with different operands → ignored; result still matches the first operation.
  - Start asserted during the done cycle → accepted; second done follows 4 cycles later, correct for the second operands.
  - Changing a and b during RUN does not alter the result.
- Reset mid-op: drop rstN two cycles into RUN → outputs go to 0 immediately, no done pulse. After release, a new start completes correctly.
